mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/pdp_pkg.sv | 18 +
 rtl/mem_arb_select.sv | 33 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp_pkg.sv
// Shared PDP-8 codebase definitions: word/address widths and the memory
// arbiter's state and requester-id encodings.
package pdp_pkg;

  localparam int PDP_ADDR_WIDTH = 12;
  localparam int PDP_DATA_WIDTH = 12;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_IFU  = 1'b0,
    REQ_EXEC = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select for the memory arbiter: exec normally wins, but after
// MAX_STREAK exec grants while a fetch waits, the fetch is let through.
module mem_arb_select #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_grant_en,
  input  logic i_ifu_req,
  input  logic i_exec_req,
  output logic o_ifu_win,
  output logic o_exec_win
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic       w_ifu_starved;

  assign w_ifu_starved = i_ifu_req && (r_streak == STREAK_MAX);
  assign o_exec_win    = i_grant_en && i_exec_req && !w_ifu_starved;
  assign o_ifu_win     = i_grant_en && i_ifu_req && !o_exec_win;

  // The streak only measures exec grants taken while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (reset || !i_ifu_req || o_ifu_win) begin
      r_streak <= '0;
    end else if (o_exec_win && (r_streak < STREAK_MAX)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction fetch unit and the
// execute unit; at most one access is in flight at any time.
module mem_arbiter
  import pdp_pkg::*;
#(
  parameter int ADDR_WIDTH = PDP_ADDR_WIDTH,
  parameter int DATA_WIDTH = PDP_DATA_WIDTH,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_gnt,
  output logic                  ifu_rd_valid,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_gnt,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output arb_state_e            dbg_state
);

  // Handshake: a requester holds req and its address/data stable until the
  // cycle its gnt pulses; a granted read returns exactly one rd_valid pulse
  // in the following cycle, a granted write completes in the grant cycle.

  arb_state_e            r_state, w_next_state;
  req_id_e               r_rd_id, w_next_id;
  logic [DATA_WIDTH-1:0] r_ifu_rd_data;
  logic [DATA_WIDTH-1:0] r_exec_rd_data;
  logic                  w_ifu_win;
  logic                  w_exec_win;
  logic                  w_grant_en;

  assign w_grant_en = (r_state == IDLE) && !reset;
  assign dbg_state  = r_state;

  mem_arb_select #(
    .MAX_STREAK (MAX_STREAK)
  ) u_select (
    .clk        (clk),
    .reset      (reset),
    .i_grant_en (w_grant_en),
    .i_ifu_req  (ifu_rd_req),
    .i_exec_req (exec_rd_req || exec_wr_req),
    .o_ifu_win  (w_ifu_win),
    .o_exec_win (w_exec_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rd_id        <= REQ_IFU;
      r_ifu_rd_data  <= '0;
      r_exec_rd_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_rd_id <= w_next_id;
      if (ifu_rd_valid) r_ifu_rd_data <= mem_rd_data;
      if (exec_rd_valid) r_exec_rd_data <= mem_rd_data;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_id     = r_rd_id;
    ifu_gnt       = 1'b0;
    exec_gnt      = 1'b0;
    ifu_rd_valid  = 1'b0;
    exec_rd_valid = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          // A simultaneous rd+wr from exec is resolved as a write.
          if (w_exec_win) begin
            exec_gnt = 1'b1;
            mem_req  = 1'b1;
            mem_we   = exec_wr_req;
            mem_addr = exec_addr;
            if (exec_wr_req) begin
              mem_wr_data = exec_wr_data;
            end else begin
              w_next_state = RD_WAIT;
              w_next_id    = REQ_EXEC;
            end
          end else if (w_ifu_win) begin
            ifu_gnt      = 1'b1;
            mem_req      = 1'b1;
            mem_addr     = ifu_rd_addr;
            w_next_state = RD_WAIT;
            w_next_id    = REQ_IFU;
          end
        end
        RD_WAIT: begin
          if (r_rd_id == REQ_IFU) ifu_rd_valid = 1'b1;
          else exec_rd_valid = 1'b1;
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
    // Returned word passes straight through in its valid cycle, then holds.
    ifu_rd_data  = reset ? '0 : (ifu_rd_valid ? mem_rd_data : r_ifu_rd_data);
    exec_rd_data = reset ? '0 : (exec_rd_valid ? mem_rd_data : r_exec_rd_data);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked by a
// negedge monitor against a reference memory and arbitration model.
module tb_mem_arbiter;
  import pdp_pkg::*;

  localparam int AW = 12;
  localparam int DW = 12;
  localparam int MAX_STREAK = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_rd_req = 1'b0;
  logic [AW-1:0] ifu_rd_addr = '0;
  logic          ifu_gnt;
  logic          ifu_rd_valid;
  logic [DW-1:0] ifu_rd_data;
  logic          exec_rd_req = 1'b0;
  logic          exec_wr_req = 1'b0;
  logic [AW-1:0] exec_addr = '0;
  logic [DW-1:0] exec_wr_data = '0;
  logic          exec_gnt;
  logic          exec_rd_valid;
  logic [DW-1:0] exec_rd_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  arb_state_e    dbg_state;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_STREAK (MAX_STREAK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_rd_req    (ifu_rd_req),
    .ifu_rd_addr   (ifu_rd_addr),
    .ifu_gnt       (ifu_gnt),
    .ifu_rd_valid  (ifu_rd_valid),
    .ifu_rd_data   (ifu_rd_data),
    .exec_rd_req   (exec_rd_req),
    .exec_wr_req   (exec_wr_req),
    .exec_addr     (exec_addr),
    .exec_wr_data  (exec_wr_data),
    .exec_gnt      (exec_gnt),
    .exec_rd_valid (exec_rd_valid),
    .exec_rd_data  (exec_rd_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory device (driven by the DUT bus) ----------------
  logic [DW-1:0] dev_mem [4096];
  logic [DW-1:0] ref_mem [4096];

  always @(posedge clk) begin
    if (!reset && mem_req && !mem_we) mem_rd_data <= dev_mem[mem_addr];
    else mem_rd_data <= DW'($urandom);
    if (!reset && mem_req && mem_we) dev_mem[mem_addr] <= mem_wr_data;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ifu_q[$];
  logic [DW-1:0] exec_q[$];

  logic     busy = 1'b0;
  logic     busy_exec = 1'b0;
  int       streak = 0;
  logic [DW-1:0] last_ifu = '0;
  logic [DW-1:0] last_exec = '0;
  logic     ifu_gnt_seen = 1'b0;
  logic     exec_gnt_seen = 1'b0;
  int       cycle = 0;
  int       gnt_cyc = 0;
  int       valid_cyc = 0;
  logic [DW-1:0] obs_ifu_data = '0;
  int       obs_exec_gnt = 0;
  int       obs_ifu_gnt = 0;
  int       obs_we = 0;
  int       obs_valid = 0;
  int       run = 0;
  int       max_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic exec_pend, exp_exec, exp_ifu;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        check("reset_outputs", {ifu_gnt, exec_gnt, ifu_rd_valid, exec_rd_valid, mem_req,
              mem_we, mem_addr, mem_wr_data, ifu_rd_data, exec_rd_data}, '0);
        if (ifu_rd_valid || exec_rd_valid) obs_valid++;
        ifu_q.delete();
        exec_q.delete();
        busy = 1'b0;
        busy_exec = 1'b0;
        streak = 0;
        run = 0;
        last_ifu = '0;
        last_exec = '0;
        ifu_gnt_seen = 1'b0;
        exec_gnt_seen = 1'b0;
      end else begin
        exec_pend = exec_rd_req || exec_wr_req;
        exp_exec = !busy && exec_pend && !(ifu_rd_req && streak == MAX_STREAK);
        exp_ifu = !busy && ifu_rd_req && !exp_exec;
        check("state_rd_wait", dbg_state == RD_WAIT, busy);
        check("ifu_gnt", ifu_gnt, exp_ifu);
        check("exec_gnt", exec_gnt, exp_exec);
        check("mem_req", mem_req, exp_ifu || exp_exec);
        if (exp_exec) begin
          check("exec_mem_we", mem_we, exec_wr_req);
          check("exec_mem_addr", mem_addr, exec_addr);
          if (exec_wr_req) begin
            check("exec_mem_wr_data", mem_wr_data, exec_wr_data);
            ref_mem[exec_addr] = exec_wr_data;
          end else begin
            exec_q.push_back(ref_mem[exec_addr]);
          end
        end
        if (exp_ifu) begin
          check("ifu_mem_we", mem_we, 1'b0);
          check("ifu_mem_addr", mem_addr, ifu_rd_addr);
          ifu_q.push_back(ref_mem[ifu_rd_addr]);
        end
        check("ifu_rd_valid", ifu_rd_valid, busy && !busy_exec);
        check("exec_rd_valid", exec_rd_valid, busy && busy_exec);
        if (ifu_rd_valid) begin
          if (ifu_q.size() == 0) begin
            check("ifu_rd_valid_unexpected", ifu_rd_valid, 1'b0);
          end else begin
            exp_d = ifu_q.pop_front();
            check("ifu_rd_data", ifu_rd_data, exp_d);
            last_ifu = exp_d;
          end
          obs_ifu_data = ifu_rd_data;
          valid_cyc = cycle;
        end else begin
          check("ifu_rd_data_hold", ifu_rd_data, last_ifu);
        end
        if (exec_rd_valid) begin
          if (exec_q.size() == 0) begin
            check("exec_rd_valid_unexpected", exec_rd_valid, 1'b0);
          end else begin
            exp_d = exec_q.pop_front();
            check("exec_rd_data", exec_rd_data, exp_d);
            last_exec = exp_d;
          end
        end else begin
          check("exec_rd_data_hold", exec_rd_data, last_exec);
        end
        // observation counters for the directed scenarios
        if (exec_gnt) obs_exec_gnt++;
        if (ifu_gnt) begin
          obs_ifu_gnt++;
          gnt_cyc = cycle;
        end
        if (mem_req && mem_we) obs_we++;
        if (ifu_rd_valid || exec_rd_valid) obs_valid++;
        if (ifu_gnt || !ifu_rd_req) run = 0;
        else if (exec_gnt) run++;
        if (run > max_run) max_run = run;
        // advance the reference model
        busy = exp_ifu || (exp_exec && !exec_wr_req);
        busy_exec = exp_exec;
        if (exp_ifu || !ifu_rd_req) streak = 0;
        else if (exp_exec && streak < MAX_STREAK) streak++;
        ifu_gnt_seen = ifu_gnt;
        exec_gnt_seen = exec_gnt;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    ifu_rd_req = 1'b0;
    exec_rd_req = 1'b0;
    exec_wr_req = 1'b0;
  endtask

  task automatic wait_gnt(input bit is_exec, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_exec ? exec_gnt_seen : ifu_gnt_seen) && n < 50);
    if (n >= 50) begin
      if (is_exec) check("exec_gnt_timeout", exec_gnt_seen, 1'b1);
      else check("ifu_gnt_timeout", ifu_gnt_seen, 1'b1);
    end
  endtask

  task automatic drive_random(input int p_ifu, input int p_exec, input int p_wr);
    bit wr;
    if (!ifu_rd_req || ifu_gnt_seen) begin
      ifu_rd_req = ($urandom_range(0, 99) < p_ifu);
      ifu_rd_addr = AW'($urandom_range(0, 15));
    end
    if (!(exec_rd_req || exec_wr_req) || exec_gnt_seen) begin
      if ($urandom_range(0, 99) < p_exec) begin
        wr = ($urandom_range(0, 99) < p_wr);
        exec_rd_req = !wr;
        exec_wr_req = wr;
        exec_addr = AW'($urandom_range(0, 15));
        exec_wr_data = DW'($urandom);
      end else begin
        exec_rd_req = 1'b0;
        exec_wr_req = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [DW-1:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = DW'($urandom);
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    dev_mem[12'o200] = 12'o7402;
    ref_mem[12'o200] = 12'o7402;

    repeat (3) tick();

    // fetch read straight out of reset
    reset = 1'b0;
    ifu_rd_req = 1'b1;
    ifu_rd_addr = 12'o200;
    wait_gnt(1'b0, n);
    check("first_grant_latency", n, 1);
    ifu_rd_req = 1'b0;
    tick();
    check("req039_data", obs_ifu_data, 12'o7402);
    check("req039_latency", valid_cyc - gnt_cyc, 1);
    tick();

    // both units reading continuously: streak limit pattern
    max_run = 0;
    obs_ifu_gnt = 0;
    repeat (40) begin
      tick();
      drive_random(100, 100, 0);
    end
    tick();
    drop_all();
    repeat (3) tick();
    check("req040_max_exec_run", max_run, MAX_STREAK);
    check("req040_ifu_got_through", obs_ifu_gnt >= 3, 1'b1);

    // three back-to-back exec writes
    obs_exec_gnt = 0;
    obs_we = 0;
    obs_valid = 0;
    exec_wr_req = 1'b1;
    exec_addr = 12'o050;
    exec_wr_data = 12'o1234;
    repeat (3) tick();
    exec_wr_req = 1'b0;
    tick();
    check("req041_exec_gnts", obs_exec_gnt, 3);
    check("req041_mem_we", obs_we, 3);
    check("req041_no_valid", obs_valid, 0);
    check("req041_dev_mem", dev_mem[12'o050], 12'o1234);

    // reset while a fetch read is outstanding
    ifu_rd_req = 1'b1;
    ifu_rd_addr = 12'd3;
    wait_gnt(1'b0, n);
    reset = 1'b1;
    ifu_rd_req = 1'b0;
    obs_valid = 0;
    tick();
    tick();
    reset = 1'b0;
    check("req042_no_valid_in_reset", obs_valid, 0);
    exec_rd_req = 1'b1;
    exec_addr = 12'd5;
    tick();
    check("req042_gnt_after_release", exec_gnt_seen, 1'b1);
    exec_rd_req = 1'b0;
    tick();
    tick();

    // fetch arrives while an exec read is in flight
    exec_rd_req = 1'b1;
    exec_addr = 12'd7;
    wait_gnt(1'b1, n);
    exec_rd_req = 1'b0;
    ifu_rd_req = 1'b1;
    ifu_rd_addr = 12'd8;
    tick();
    check("req043_no_gnt_in_rd_wait", ifu_gnt_seen, 1'b0);
    tick();
    check("req043_ifu_gnt_next", ifu_gnt_seen, 1'b1);
    ifu_rd_req = 1'b0;
    tick();
    tick();

    // random traffic
    repeat (10000) begin
      tick();
      drive_random(60, 60, 40);
    end
    tick();
    drop_all();
    repeat (4) tick();
    check("ifu_q_drained", ifu_q.size(), 0);
    check("exec_q_drained", exec_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
